// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the KGP-RISC pipeline.
//   if_state_t : fetch-stage state encoding (S_IDLE, S_REQ, S_HOLD)
//   INSTR_W    : instruction word width
//   PC_STEP    : byte distance between sequential instructions
//   NOP_INSTR  : value presented on instr when nothing has been fetched
package kgp_risc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } if_state_t;

    localparam int unsigned   INSTR_W   = 32;
    localparam int unsigned   PC_STEP   = 4;
    localparam logic [31:0]   NOP_INSTR = 32'h0;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register for the fetch stage.
// Ports:
//   clk            : system clock
//   rst            : asynchronous active-low reset, loads RESET_PC
//   advance        : step to the next sequential instruction
//   redirect_valid : load redirect_pc (wins over advance)
//   redirect_pc    : new target; the two low bits are forced to zero
//   pc             : current fetch PC
//   pc_next        : value pc takes at the next rising edge
module pc_reg
    import kgp_risc_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_pc & ALIGN_MASK;
        end else if (advance) begin
            // Wraps naturally modulo 2^ADDR_W.
            pc_next = pc + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage of the KGP-RISC pipeline.
// Owns the PC, fetches words from instruction memory over a req/ack handshake and
// presents them to decode over valid/ready. Redirects from branch resolution discard
// any in-flight fetch.
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   imem_req, imem_addr             : registered fetch request and byte address
//   imem_ack, imem_rdata            : memory response for the outstanding request
//   redirect_valid, redirect_pc     : taken branch/jump target
//   instr, instr_pc, instr_valid    : fetched word to decode
//   id_ready                        : decode accepts instr this cycle
// Build option IF_PERF_CNT_EN adds perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt.
module instruction_fetch
    import kgp_risc_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               id_ready
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    if_state_t         state;
    logic              discard;
    logic              advance;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_next;

    assign advance = (state == S_HOLD) && id_ready;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .advance        (advance),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (fetch_pc),
        .pc_next        (pc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            discard     <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state     <= S_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc_next;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        discard <= 1'b0;
                        if (redirect_valid || discard) begin
                            // Stale data: keep requesting, now at the redirected PC.
                            imem_addr <= pc_next;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= fetch_pc;
                            instr_valid <= 1'b1;
                            imem_req    <= 1'b0;
                            state       <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Request cannot be withdrawn; address stays put until ack.
                        discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || id_ready) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc_next;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            // Only acks whose data actually reaches decode.
            if ((state == S_REQ) && imem_ack && !discard && !redirect_valid) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if ((state == S_HOLD) && !id_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
